// File: rtl/i2s_dac_tx.sv
// I2S stereo DAC transmitter.
// Converts an offset-binary mono sample to two's complement. The same word is
// sent on the left and right slots, MSB first. All BCLK-domain outputs are
// registered, and they change only on BCLK falling events.
module i2s_dac_tx #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  output logic                    o_bclk,
  output logic                    o_lrck,
  output logic                    o_sdata,
  output logic                    o_frame_tick,
  output logic                    o_underrun
);

  localparam int unsigned FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]        BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]        BIT_RIGHT = BIT_W'(SAMPLE_WIDTH - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [DIV_W-1:0]        r_div_cnt;
  logic                    r_bclk;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic                    r_lrck;
  logic                    r_sdata;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [SAMPLE_WIDTH-1:0] r_hold;
  logic                    r_full;
  logic [SAMPLE_WIDTH-1:0] r_last;
  logic                    r_frame_tick;
  logic                    r_underrun;

  logic                    w_div_wrap;
  logic                    w_fall;
  logic [BIT_W-1:0]        w_bit_next;
  logic                    w_load;
  logic                    w_accept;
  logic [SAMPLE_WIDTH-1:0] w_load_sample;
  logic [SAMPLE_WIDTH-1:0] w_conv;
  logic [FRAME_BITS-1:0]   w_frame_word;

  // Decode divider and bit-position events, plus the frame word for the next load
  always_comb begin
    w_div_wrap    = (r_div_cnt == DIV_LAST);
    w_fall        = w_div_wrap & r_bclk;
    w_bit_next    = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    w_load        = w_fall & (w_bit_next == '0);
    w_accept      = i_sample_valid & ~r_full;
    // The load decision uses the holding state before the edge, so a sample
    // accepted in the load cycle itself waits for the following frame
    w_load_sample = r_full ? r_hold : r_last;
    w_conv        = {~w_load_sample[SAMPLE_WIDTH-1], w_load_sample[SAMPLE_WIDTH-2:0]};
    w_frame_word  = {w_conv, w_conv};
  end

  // BCLK divider: toggle BCLK every CLK_DIV system clocks
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Bit position within the frame; resets to the last slot so the first fall is bit 0
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bit_cnt <= BIT_LAST;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_next;
    end
  end

  // Word select switches one BCLK ahead of each channel's MSB
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lrck <= 1'b0;
    end else if (w_fall) begin
      if (w_bit_next == BIT_LAST) begin
        r_lrck <= 1'b0;
      end else if (w_bit_next == BIT_RIGHT) begin
        r_lrck <= 1'b1;
      end
    end
  end

  // Single-entry holding register and the last sample sent (repeated on underrun)
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hold <= '0;
      r_full <= 1'b0;
      r_last <= MIDSCALE;
    end else if (w_load && r_full) begin
      r_last <= r_hold;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_hold <= i_sample;
      r_full <= 1'b1;
    end
  end

  // Serialiser: load the frame word at bit 0, then shift out MSB first on each fall
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_sdata <= 1'b0;
    end else if (w_load) begin
      r_sdata <= w_frame_word[FRAME_BITS-1];
      r_shift <= {w_frame_word[FRAME_BITS-2:0], 1'b0};
    end else if (w_fall) begin
      r_sdata <= r_shift[FRAME_BITS-1];
      r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
    end
  end

  // One-cycle frame and underrun pulses aligned with the frame load
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_frame_tick <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_tick <= w_load;
      r_underrun   <= w_load & ~r_full;
    end
  end

  assign o_sample_ready = ~r_full;
  assign o_bclk         = r_bclk;
  assign o_lrck         = r_lrck;
  assign o_sdata        = r_sdata;
  assign o_frame_tick   = r_frame_tick;
  assign o_underrun     = r_underrun;

endmodule
